verilog_frame_tx: RTL and testbench



---
 rtl/verilog_frame_tx.sv | 139 +++++++++++++
 tb/tb_verilog_frame_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/verilog_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : verilog_frame_tx
// Purpose  : Framed parallel-to-serial transmitter. A DATA_W-bit word taken
//            over a valid/ready handshake is sent LSB-first on one line as
//            {stop=1, even parity, data, start=0}. Each bit is held for
//            BIT_CYCLES clocks, and the line idles high.
// Ports    : clk         - rising-edge clock
//            rst         - asynchronous active-high reset
//            in_valid    - offered word valid
//            in_data     - offered word, sampled only at acceptance
//            in_ready    - high while IDLE (combinational)
//            tx_out      - registered serial line
//            busy        - registered, high while a frame is on the line
//            frame_count - completed frames, wraps modulo 256
// Revision : 1.0 - initial release
// ============================================================================
module verilog_frame_tx #(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic [7:0]        frame_count
);

    localparam int c_FRAME_W = DATA_W + 3;
    localparam int c_IDX_W   = $clog2(c_FRAME_W);
    localparam int c_CYC_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_FRAME_W - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(BIT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_FRAME_W-1:0] r_shreg;
    logic [c_FRAME_W-1:0] w_shreg_nxt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [c_IDX_W-1:0]   w_bit_idx_nxt;
    logic [c_CYC_W-1:0]   r_cyc;
    logic [c_CYC_W-1:0]   w_cyc_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic [7:0]           r_count;
    logic [7:0]           w_count_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_cyc     <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_cyc     <= w_cyc_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_count   <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_idx_nxt = r_bit_idx;
        w_cyc_nxt     = r_cyc;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_count_nxt   = r_count;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (in_valid) begin
                    // The start bit is the loaded LSB, so it goes straight
                    // onto the line register at the accept edge.
                    w_shreg_nxt   = {1'b1, ^in_data, in_data, 1'b0};
                    w_bit_idx_nxt = '0;
                    w_cyc_nxt     = '0;
                    w_tx_nxt      = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                w_tx_nxt = r_shreg[0];
                if (r_cyc == c_CYC_LAST) begin
                    w_cyc_nxt   = '0;
                    // Ones shift in behind the frame so the line is already
                    // high when the stop bit leaves.
                    w_shreg_nxt = {1'b1, r_shreg[DATA_W+2:1]};
                    w_tx_nxt    = w_shreg_nxt[0];
                    if (r_bit_idx == c_IDX_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_count_nxt = r_count + 8'd1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + c_IDX_W'(1);
                    end
                end else begin
                    w_cyc_nxt = r_cyc + c_CYC_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign in_ready    = (r_state == S_IDLE);
    assign tx_out      = r_tx;
    assign busy        = r_busy;
    assign frame_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_verilog_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_verilog_frame_tx
// Purpose  : Scoreboard bench for verilog_frame_tx. Stimulus pushes the
//            expected frame bits and completion count for each word; a
//            negedge monitor pops one entry per frame and checks every
//            bit-cycle plus the idle cycle that follows. A second
//            instance (DATA_W=1, BIT_CYCLES=1) covers the narrow corner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_verilog_frame_tx;

    localparam int c_BC      = 2;
    localparam int c_FRAME_W = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       tx_out;
    logic       busy;
    logic [7:0] frame_count;

    logic       in_valid_b;
    logic [0:0] in_data_b;
    logic       in_ready_b;
    logic       tx_out_b;
    logic       busy_b;
    logic [7:0] frame_count_b;

    always #5 clk = ~clk;

    verilog_frame_tx #(.DATA_W(4), .BIT_CYCLES(2)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .tx_out      (tx_out),
        .busy        (busy),
        .frame_count (frame_count)
    );

    verilog_frame_tx #(.DATA_W(1), .BIT_CYCLES(1)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_b),
        .in_data     (in_data_b),
        .in_ready    (in_ready_b),
        .tx_out      (tx_out_b),
        .busy        (busy_b),
        .frame_count (frame_count_b)
    );

    typedef struct {
        logic [c_FRAME_W-1:0] bits;
        logic [7:0]           cnt;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    logic [7:0] exp_cnt;
    int         errors = 0;
    int         checks = 0;
    bit         in_frame = 1'b0;
    bit         post = 1'b0;
    int         n = 0;
    int         cyc_n = 0;
    int         last_start = 0;
    int         prev_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the state updates.
    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            in_frame = 1'b0;
            post     = 1'b0;
        end else begin
            if (post) begin
                check("post_frame {busy,ready,tx,count}",
                      {busy, in_ready, tx_out, frame_count},
                      {1'b0, 1'b1, 1'b1, cur.cnt});
                post = 1'b0;
            end
            if (!in_frame && busy) begin
                prev_start = last_start;
                last_start = cyc_n;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: busy=1, expected no frame (t=%0t)", $time);
                end else begin
                    cur      = q.pop_front();
                    in_frame = 1'b1;
                    n        = 0;
                end
            end
            if (in_frame) begin
                check("frame_bit {busy,ready,tx}",
                      {busy, in_ready, tx_out},
                      {1'b1, 1'b0, cur.bits[n / c_BC]});
                n++;
                if (n == c_FRAME_W * c_BC) begin
                    in_frame = 1'b0;
                    post     = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        #1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: in_ready=0, expected 1 within 100 cycles");
        end
    endtask

    task automatic send(input logic [3:0] d, input logic [6:0] bits, input bit keep);
        wait_ready();
        in_data  = d;
        in_valid = 1'b1;
        exp_cnt  = exp_cnt + 8'd1;
        q.push_back('{bits, exp_cnt});
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((q.size() != 0 || in_frame || post) && t < 400) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (q.size() != 0 || in_frame || post) begin
            checks++;
            errors++;
            $display("FAIL wait_done: frame still pending, expected completion within 400 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d;
        logic [3:0] bexp;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 4'h0;
        in_valid_b = 1'b0;
        in_data_b  = 1'b0;
        exp_cnt    = 8'd0;

        // Reset state while rst is held across clock edges
        repeat (2) @(posedge clk);
        #1;
        check("reset {tx,busy,ready,count}", {tx_out, busy, in_ready, frame_count},
              {1'b1, 1'b0, 1'b1, 8'd0});
        check("reset_b {tx,busy,ready,count}", {tx_out_b, busy_b, in_ready_b, frame_count_b},
              {1'b1, 1'b0, 1'b1, 8'd0});
        rst = 1'b0;

        // 1011, parity 1
        send(4'b1011, 7'b1110110, 1'b0);
        wait_done();

        // 0000, parity 0; data changes mid-frame must be ignored
        send(4'b0000, 7'b1000000, 1'b0);
        repeat (4) @(posedge clk);
        #1 in_data = 4'hF;
        wait_done();

        // valid held high: A then 5, both parity 0
        send(4'hA, 7'b1010100, 1'b1);
        send(4'h5, 7'b1001010, 1'b0);
        wait_done();
        check("start_spacing", last_start - prev_start, 15);

        // Asynchronous reset during data bit 2 (cycles 7-8 after accept)
        send(4'b1011, 7'b1110110, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset {tx,busy,ready,count}", {tx_out, busy, in_ready, frame_count},
              {1'b1, 1'b0, 1'b1, 8'd0});
        @(posedge clk);
        #2 rst = 1'b0;
        q.delete();
        exp_cnt = 8'd0;
        send(4'h3, 7'b1000110, 1'b0);
        wait_done();

        // 256 back-to-back frames from a clean count
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            d = 4'(i);
            send(d, {1'b1, ^d, d, 1'b0}, (i != 255));
        end
        wait_done();
        check("count_wrap", frame_count, 8'h00);

        // Narrow instance: DATA_W=1, BIT_CYCLES=1, data 1 -> 0,1,1,1
        bexp = 4'b1110;
        @(negedge clk);
        check("b_idle_ready", in_ready_b, 1'b1);
        in_data_b  = 1'b1;
        in_valid_b = 1'b1;
        @(posedge clk);
        #1 in_valid_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b_frame_bit {busy,ready,tx}", {busy_b, in_ready_b, tx_out_b},
                  {1'b1, 1'b0, bexp[k]});
        end
        @(negedge clk);
        check("b_post {busy,ready,tx,count}", {busy_b, in_ready_b, tx_out_b, frame_count_b},
              {1'b0, 1'b1, 1'b1, 8'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
